mseq_barker_src: RTL and testbench

Frame source feeding the QPSK serial-to-parallel stage. The block emits a continuous stream of frames on `clk_fs`. Each frame is a 13-bit Barker preamble followed by `PAYLOAD_LEN` bits of a free-running m-sequence. Every bit is presented as a bipolar 2-bit symbol held for `BIT_CYCLES` clocks, which matches the every-other-clock sampling rate of the downstream I/Q splitter.

---
 rtl/mseq_pkg.sv | 21 ++
 rtl/lfsr_core.sv | 30 +++
 rtl/mseq_barker_src.sv | 126 ++++++++++++
 tb/tb_mseq_barker_src.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// Shared constants and types for the Barker/m-sequence frame source.
// Barker code, FSM state encoding and bipolar symbol values.
package mseq_pkg;

  localparam logic [12:0] BARKER13 = 13'b1111100110101;

  typedef enum logic [1:0] {
    IDLE,
    BARKER,
    PAYLOAD
  } state_t;

  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_IDLE = 2'b00;

  function automatic logic [1:0] sym_of(input logic b);
    return b ? SYM_POS : SYM_NEG;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR, MSB out, shifting toward the MSB on each advance.
// An all-zero state reloads the seed on the next advance.
module lfsr_core #(
  parameter int                W    = 7,
  parameter logic [W-1:0]      TAPS = 7'b1100000,
  parameter logic [W-1:0]      SEED = 7'b0000001
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  output logic bit_out
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  logic [W-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= SEED_EFF;
    end else if (adv) begin
      if (r_lfsr == '0) r_lfsr <= SEED_EFF;
      else r_lfsr <= {r_lfsr[W-2:0], ^(r_lfsr & TAPS)};
    end
  end

  assign bit_out = r_lfsr[W-1];

endmodule

// File: rtl/mseq_barker_src.sv
// Frame source: 13-bit Barker preamble then PAYLOAD_LEN m-sequence bits.
// Optional frame counter port guarded by MSEQ_SRC_FRAME_CNT_EN.
module mseq_barker_src
  import mseq_pkg::*;
#(
  parameter int                    BIT_CYCLES  = 2,
  parameter int                    LFSR_WIDTH  = 7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 7'b1100000,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 7'b0000001,
  parameter int                    PAYLOAD_LEN = 127
) (
  input  logic        clk_fs,
  input  logic        rst_n,
  input  logic        en,
  output logic [1:0]  data_out,
  output logic        bit_strobe,
  output logic        frame_start,
  output logic        in_preamble
`ifdef MSEQ_SRC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [3:0]  DIV_LAST = 4'(BIT_CYCLES - 1);
  localparam logic [15:0] P_LAST   = 16'(PAYLOAD_LEN - 1);

  state_t      r_state;
  logic [3:0]  r_div;
  logic        r_arm;
  logic [3:0]  r_bidx;
  logic [15:0] r_pidx;

  logic        w_wrap;
  logic        w_adv;
  logic        w_lbit;
  logic [3:0]  w_bsel;

  assign w_wrap = en & r_arm & (r_div == DIV_LAST);
  assign w_bsel = 4'd11 - r_bidx;

  // LFSR steps exactly when a payload bit is loaded onto data_out.
  assign w_adv = w_wrap &
    (((r_state == BARKER) & (r_bidx == 4'd12)) |
     ((r_state == PAYLOAD) & (r_pidx != P_LAST)));

  lfsr_core #(
    .W    (LFSR_WIDTH),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk_fs),
    .rst_n   (rst_n),
    .adv     (w_adv),
    .bit_out (w_lbit)
  );

  always_ff @(posedge clk_fs) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_arm       <= 1'b0;
      r_bidx      <= '0;
      r_pidx      <= '0;
      data_out    <= SYM_IDLE;
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      in_preamble <= 1'b0;
`ifdef MSEQ_SRC_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        if (!r_arm) begin
          // First enabled edge only arms; the next one is a strobe slot.
          r_arm <= 1'b1;
          r_div <= DIV_LAST;
        end else begin
          r_div <= w_wrap ? 4'd0 : r_div + 4'd1;
        end
        if (w_wrap) begin
          bit_strobe <= 1'b1;
          unique case (r_state)
            IDLE: begin
              r_state     <= BARKER;
              r_bidx      <= '0;
              data_out    <= sym_of(BARKER13[12]);
              in_preamble <= 1'b1;
              frame_start <= 1'b1;
            end
            BARKER: begin
              if (r_bidx == 4'd12) begin
                r_state     <= PAYLOAD;
                r_pidx      <= '0;
                data_out    <= sym_of(w_lbit);
                in_preamble <= 1'b0;
              end else begin
                r_bidx   <= r_bidx + 4'd1;
                data_out <= sym_of(BARKER13[w_bsel]);
              end
            end
            PAYLOAD: begin
              if (r_pidx == P_LAST) begin
                r_state     <= BARKER;
                r_bidx      <= '0;
                data_out    <= sym_of(BARKER13[12]);
                in_preamble <= 1'b1;
                frame_start <= 1'b1;
`ifdef MSEQ_SRC_FRAME_CNT_EN
                frame_cnt   <= frame_cnt + 16'd1;
`endif
              end else begin
                r_pidx   <= r_pidx + 16'd1;
                data_out <= sym_of(w_lbit);
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mseq_barker_src.sv
// Randomised-enable bench for mseq_barker_src against a symbol-level model.
// Checks default build and a BIT_CYCLES=1, PAYLOAD_LEN=3 instance.
module tb_mseq_barker_src;

  localparam int BC1 = 2;
  localparam int PL1 = 127;
  localparam int FL1 = 13 + PL1;
  localparam int PL2 = 3;
  localparam int FL2 = 13 + PL2;
  localparam logic [12:0] BK = 13'b1111100110101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en2 = 1'b1;

  logic [1:0] d1, d2;
  logic bs1, fs1, ip1, bs2, fs2, ip2;
`ifdef MSEQ_SRC_FRAME_CNT_EN
  logic [15:0] fc1, fc2;
`endif

  int n_tests = 0;
  int n_fail = 0;

  bit mseq [127];
  logic rst_q = 1'b0, en_q = 1'b0;
  bit live = 0;
  int ncyc = 0;

  always #5 clk = ~clk;

  mseq_barker_src u_dut1 (
    .clk_fs      (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_out    (d1),
    .bit_strobe  (bs1),
    .frame_start (fs1),
    .in_preamble (ip1)
`ifdef MSEQ_SRC_FRAME_CNT_EN
    ,
    .frame_cnt   (fc1)
`endif
  );

  mseq_barker_src #(
    .BIT_CYCLES  (1),
    .PAYLOAD_LEN (PL2)
  ) u_dut2 (
    .clk_fs      (clk),
    .rst_n       (rst_n),
    .en          (en2),
    .data_out    (d2),
    .bit_strobe  (bs2),
    .frame_start (fs2),
    .in_preamble (ip2)
`ifdef MSEQ_SRC_FRAME_CNT_EN
    ,
    .frame_cnt   (fc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sym(input int k, input int pl);
    int fl, f, p;
    bit b;
    fl = 13 + pl;
    f = k / fl;
    p = k % fl;
    if (p < 13) b = BK[12-p];
    else b = mseq[(f * pl + p - 13) % 127];
    return b ? 2'b01 : 2'b11;
  endfunction

  always @(posedge clk) begin
    rst_q <= rst_n;
    en_q  <= en;
    live  <= 1'b1;
    ncyc  <= ncyc + 1;
  end

  int k1 = 0, cyc1 = 0, nfs1 = 0;
  bit first1 = 1;
  logic [1:0] prev1 = 2'b00;
  logic prevp1 = 1'b0;

  always @(negedge clk) begin
    int gap, p;
    if (live) begin
      if (!rst_q) begin
        chk("rst1", {27'd0, d1, bs1, fs1, ip1}, 32'd0);
`ifdef MSEQ_SRC_FRAME_CNT_EN
        chk("rstcnt1", {16'd0, fc1}, 32'd0);
`endif
        k1 = 0; cyc1 = 0; first1 = 1; nfs1 = 0;
      end else if (!en_q) begin
        chk("hold1", {27'd0, bs1, fs1, d1, ip1},
            {27'd0, 2'b00, prev1, prevp1});
      end else begin
        cyc1++;
        gap = first1 ? 2 : BC1;
        chk("stb1", {31'd0, bs1}, {31'd0, 1'(cyc1 == gap)});
        if (bs1) begin
          p = k1 % FL1;
          chk("sym1", {30'd0, d1}, {30'd0, exp_sym(k1, PL1)});
          chk("fs1", {31'd0, fs1}, {31'd0, 1'(p == 0)});
          chk("pre1", {31'd0, ip1}, {31'd0, 1'(p < 13)});
          if (fs1) begin
            nfs1++;
`ifdef MSEQ_SRC_FRAME_CNT_EN
            chk("fcnt1", {16'd0, fc1}, 32'(nfs1 - 1));
`endif
          end
          k1++;
          first1 = 0;
        end
        if (bs1 || cyc1 >= gap) cyc1 = 0;
      end
    end
    prev1  = d1;
    prevp1 = ip1;
  end

  int k2 = 0, cyc2 = 0, lastfs2 = -1;
  bit first2 = 1;

  always @(negedge clk) begin
    int gap, p;
    if (live) begin
      if (!rst_q) begin
        chk("rst2", {27'd0, d2, bs2, fs2, ip2}, 32'd0);
        k2 = 0; cyc2 = 0; first2 = 1; lastfs2 = -1;
      end else begin
        cyc2++;
        gap = first2 ? 2 : 1;
        chk("stb2", {31'd0, bs2}, {31'd0, 1'(cyc2 == gap)});
        if (bs2) begin
          p = k2 % FL2;
          chk("sym2", {30'd0, d2}, {30'd0, exp_sym(k2, PL2)});
          chk("fs2", {31'd0, fs2}, {31'd0, 1'(p == 0)});
          chk("pre2", {31'd0, ip2}, {31'd0, 1'(p < 13)});
          if (fs2) begin
            if (lastfs2 >= 0) chk("per2", 32'(ncyc - lastfs2), 32'd16);
            lastfs2 = ncyc;
          end
          k2++;
          first2 = 0;
        end
        if (bs2 || cyc2 >= gap) cyc2 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_k(input int target, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (k1 >= target) return;
      tick();
    end
    chk("timeout", 32'(k1), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 7; i++) mseq[i] = (i == 6);
    for (int n = 0; n < 120; n++) mseq[n+7] = mseq[n] ^ mseq[n+1];

    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    en = 1'b1;

    wait_k(13 + 30, 1000);
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;

    wait_k(FL1 + 13 + 41, 2000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick();
    end
    en = 1'b1;
    repeat (400) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
